// File: rtl/compression_pkg.sv
// Shared types and constants for the compression pipeline output stage.
package compression_pkg;

  // Default word width of the packed words leaving the compression pipeline.
  localparam int AHB_WIDTH_DEFAULT = 32;

  // Frame tracking states of the output FIFO.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } cfifo_state_t;

  // Increment a 32-bit counter, holding at its maximum value.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cfifo_ram.sv
// Simple dual-port word RAM: one write port, one registered read port.
// The read register has a synchronous reset so it maps onto a block RAM
// output register; reads return the old contents on an address collision.
module cfifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Write port: store the incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port next value: clear, load on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (srst) begin
      rdata_d = {WIDTH{1'b0}};
    end else if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/compression_out_fifo.sv
// Output word FIFO of the compression pipeline. Captures every packed word
// (no upstream backpressure), tracks one frame from start to idle timeout,
// and is drained by the AHB slave wrapper with one cycle read latency.
module compression_out_fifo
  import compression_pkg::*;
#(
  parameter int AHB_WIDTH    = AHB_WIDTH_DEFAULT,
  parameter int DEPTH        = 256,
  parameter int AF_LEVEL     = 224,
  parameter int IDLE_TIMEOUT = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [AHB_WIDTH-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 rd_req,
  output logic [AHB_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [31:0]          frame_words,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF    = CW'(AF_LEVEL);
  localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);

  cfifo_state_t  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [31:0]   frame_words_q, frame_words_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;

  logic          push_acc;
  logic          pop_acc;
  logic          drop;

  // Decide which of this cycle's push/pop requests take effect.
  always_comb begin
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    drop     = 1'b0;
    if (clear) begin
      // A clear discards both requests without flagging overflow.
      push_acc = 1'b0;
      pop_acc  = 1'b0;
      drop     = 1'b0;
    end else begin
      pop_acc  = rd_req && (count_q != {CW{1'b0}});
      // A full FIFO still takes a word when a pop frees a slot this cycle.
      push_acc = valid_in && ((count_q < CNT_DEPTH) || pop_acc);
      drop     = valid_in && !push_acc;
    end
  end

  // Next-state logic for pointers, occupancy, frame tracking and flags.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    idle_d        = idle_q;
    frame_words_d = frame_words_q;
    overflow_d    = overflow_q;
    if (clear) begin
      state_d       = IDLE;
      wr_ptr_d      = {AW{1'b0}};
      rd_ptr_d      = {AW{1'b0}};
      count_d       = {CW{1'b0}};
      idle_d        = {IW{1'b0}};
      frame_words_d = 32'd0;
      overflow_d    = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      // start re-arms the sticky flag; a drop in the same cycle still shows.
      overflow_d = (start ? 1'b0 : overflow_q) | drop;

      // Only words arriving while a frame is active belong to it.
      if (start) begin
        frame_words_d = 32'd0;
      end else if ((state_q == ACTIVE) && push_acc) begin
        frame_words_d = sat_inc32(frame_words_q);
      end else begin
        frame_words_d = frame_words_q;
      end

      // Quiet-time counter; frozen until the frame has produced a word.
      if (start || push_acc) begin
        idle_d = {IW{1'b0}};
      end else if ((state_q == ACTIVE) && !valid_in &&
                   (frame_words_q != 32'd0) && (idle_q != IDLE_MAX)) begin
        idle_d = idle_q + IDLE_ONE;
      end else begin
        idle_d = idle_q;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
        ACTIVE: begin
          if (start) begin
            state_d = ACTIVE;
          end else if ((idle_q == IDLE_MAX) && (frame_words_q != 32'd0) && !valid_in) begin
            state_d = DONE;
          end else begin
            state_d = ACTIVE;
          end
        end
        DONE: begin
          if (start) begin
            state_d = ACTIVE;
          end else begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output flags are derived from next-cycle values so they register in step.
  always_comb begin
    empty_d       = (count_d == {CW{1'b0}});
    full_d        = (count_d == CNT_DEPTH);
    almost_full_d = (count_d >= CNT_AF);
    busy_d        = (state_d == ACTIVE);
    done_d        = (state_d == DONE);
    rd_valid_d    = pop_acc;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {CW{1'b0}};
      idle_q        <= {IW{1'b0}};
      frame_words_q <= 32'd0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      idle_q        <= idle_d;
      frame_words_q <= frame_words_d;
      empty_q       <= empty_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  cfifo_ram #(
    .WIDTH (AHB_WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .srst  (clear),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .re    (pop_acc),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign frame_words = frame_words_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
